sdpram_be_bypass: RTL and testbench

Parametrised single-clock simple dual-port RAM with per-byte write enables, registered read and an optional second output register. It is the successor to the fixed 4Kx8 SDP block and generalises address width, data width and byte size. It adds three things the fixed block lacks: read enable, a read-valid strobe, and byte-accurate write-first collision bypass. It is used as a generic buffer inside the FPGA shell's peripheral and DMA datapaths.

---
 rtl/sdpram_pkg.sv | 50 +++++
 rtl/sdpram_array.sv | 46 ++++
 rtl/sdpram_be_bypass.sv | 190 +++++++++++++++++++
 tb/tb_sdpram_be_bypass.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdpram_pkg.sv
// Shared constants and helpers for the byte-enabled simple dual-port RAM.
//
// Contents:
//   BYTE_SIZE_EIGHT / BYTE_SIZE_NINE  legal byte-lane widths
//   MAX_WORD_W / MAX_LANES            upper bound for the generic helpers below
//   lane_merge()                      per-lane select between an old and a new word
//   lane_parity()                     XOR-reduce of every lane of a word
//
// The helpers work on a fixed maximum width. Callers size-cast their words
// in and out, and pass the lane width. Constant lane widths fold away in
// synthesis.
package sdpram_pkg;

    localparam int unsigned BYTE_SIZE_EIGHT = 8;
    localparam int unsigned BYTE_SIZE_NINE  = 9;

    localparam int unsigned MAX_WORD_W = 640;
    localparam int unsigned MAX_LANES  = MAX_WORD_W / BYTE_SIZE_EIGHT;

    // Lanes with mask=1 take new_word, the rest keep old_word.
    function automatic logic [MAX_WORD_W-1:0] lane_merge(
        input logic [MAX_WORD_W-1:0] old_word,
        input logic [MAX_WORD_W-1:0] new_word,
        input logic [MAX_LANES-1:0]  mask,
        input int unsigned           lane_w
    );
        logic [MAX_WORD_W-1:0] merged;
        merged = old_word;
        for (int unsigned j = 0; j < MAX_WORD_W; j++) begin
            if (mask[j / lane_w]) begin
                merged[j] = new_word[j];
            end
        end
        return merged;
    endfunction

    // Even-parity bit per lane: bit l is the XOR of lane l.
    function automatic logic [MAX_LANES-1:0] lane_parity(
        input logic [MAX_WORD_W-1:0] word,
        input int unsigned           lane_w
    );
        logic [MAX_LANES-1:0] par;
        par = '0;
        for (int unsigned j = 0; j < MAX_WORD_W; j++) begin
            par[j / lane_w] = par[j / lane_w] ^ word[j];
        end
        return par;
    endfunction

endpackage

// File: rtl/sdpram_array.sv
// Raw storage for the simple dual-port RAM. It has a lane-masked write port
// and a registered read port. There is no reset and no bypass, so synthesis
// can map it onto block RAM. A read at the same edge as a write returns the
// old contents.
//
// Ports:
//   clk         clock, rising edge
//   wr_en       write strobe
//   wr_addr     write address
//   wr_data     write word (LANES lanes of LANE_WIDTH bits)
//   wr_lane_en  per-lane write enable
//   rd_en       read strobe; rd_data updates only when set
//   rd_addr     read address
//   rd_data     registered read word
module sdpram_array #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LANE_WIDTH = 8,
    parameter int unsigned LANES      = 4
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [LANES*LANE_WIDTH-1:0]   wr_data,
    input  logic [LANES-1:0]              wr_lane_en,
    input  logic                          rd_en,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic [LANES*LANE_WIDTH-1:0]   rd_data
);

    logic [LANES*LANE_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (wr_lane_en[l]) begin
                    mem[wr_addr][l*LANE_WIDTH +: LANE_WIDTH] <=
                        wr_data[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sdpram_be_bypass.sv
// Parametrised single-clock simple dual-port RAM. It has per-byte write
// enables, a registered read, an optional second output register, a
// read-valid strobe and byte-accurate write-first collision bypass.
//
// Optional feature macro: SDPRAM_PARITY_EN. When defined, the RAM stores
// one even-parity bit per lane and adds these ports:
//   wr_par_inj  in   BE_WIDTH  invert stored parity of written lanes
//   rd_par_err  out  BE_WIDTH  per-lane parity error, pipelined with rd_data
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   wr_en       write strobe
//   wr_addr     write address
//   wr_data     write data
//   wr_byte_en  per-lane write enable
//   rd_en       read request
//   rd_addr     read address
//   rd_data     read data, valid with rd_valid
//   rd_valid    read result strobe (latency 1 + OUTPUT_REG)
module sdpram_be_bypass
    import sdpram_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 12,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned BYTE_SIZE  = 8,
    parameter  int unsigned OUTPUT_REG = 1,
    localparam int unsigned BE_WIDTH   = DATA_WIDTH / BYTE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_byte_en,
`ifdef SDPRAM_PARITY_EN
    input  logic [BE_WIDTH-1:0]   wr_par_inj,
    output logic [BE_WIDTH-1:0]   rd_par_err,
`endif
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

`ifdef SDPRAM_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    // Each stored lane is {parity, byte} when parity is enabled.
    localparam int unsigned LANE_W = BYTE_SIZE + PAR_W;
    localparam int unsigned MEM_W  = BE_WIDTH * LANE_W;

    if ((DATA_WIDTH % BYTE_SIZE) != 0 ||
        (BYTE_SIZE != BYTE_SIZE_EIGHT && BYTE_SIZE != BYTE_SIZE_NINE)) begin : g_bad_cfg
        $error("sdpram_be_bypass: DATA_WIDTH must be a multiple of BYTE_SIZE (8 or 9)");
    end
    if (MEM_W > MAX_WORD_W) begin : g_too_wide
        $error("sdpram_be_bypass: stored word wider than sdpram_pkg::MAX_WORD_W");
    end

    // ---------------------------------------------------------------- write word
    logic [MEM_W-1:0] wr_word;
`ifdef SDPRAM_PARITY_EN
    logic [BE_WIDTH-1:0] wr_par;
    assign wr_par = BE_WIDTH'(lane_parity(MAX_WORD_W'(wr_data), BYTE_SIZE)) ^ wr_par_inj;
`endif

    always_comb begin
        wr_word = '0;
        for (int unsigned l = 0; l < BE_WIDTH; l++) begin
            wr_word[l*LANE_W +: BYTE_SIZE] = wr_data[l*BYTE_SIZE +: BYTE_SIZE];
`ifdef SDPRAM_PARITY_EN
            wr_word[l*LANE_W + BYTE_SIZE] = wr_par[l];
`endif
        end
    end

    // ---------------------------------------------------------------- storage
    logic [MEM_W-1:0] arr_q;

    sdpram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANE_WIDTH (LANE_W),
        .LANES      (BE_WIDTH)
    ) u_array (
        .clk        (clk),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_word),
        .wr_lane_en (wr_byte_en),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (arr_q)
    );

    // ---------------------------------------------------------------- stage 1
    // The array register has no reset. s1_loaded forces stage 1 to zero until
    // the first read after reset. Bypass lanes and data are captured beside the
    // array read and merged on its output.
    logic                s1_valid;
    logic                s1_loaded;
    logic [BE_WIDTH-1:0] byp_mask;
    logic [MEM_W-1:0]    byp_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_loaded <= 1'b0;
            byp_mask  <= '0;
            byp_word  <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_loaded <= 1'b1;
                byp_mask  <= (wr_en && (wr_addr == rd_addr)) ? wr_byte_en : '0;
                byp_word  <= wr_word;
            end
        end
    end

    logic [MEM_W-1:0]      s1_word;
    logic [DATA_WIDTH-1:0] s1_data;

    assign s1_word = s1_loaded
        ? MEM_W'(lane_merge(MAX_WORD_W'(arr_q), MAX_WORD_W'(byp_word),
                            MAX_LANES'(byp_mask), LANE_W))
        : '0;

    always_comb begin
        s1_data = '0;
        for (int unsigned l = 0; l < BE_WIDTH; l++) begin
            s1_data[l*BYTE_SIZE +: BYTE_SIZE] = s1_word[l*LANE_W +: BYTE_SIZE];
        end
    end

`ifdef SDPRAM_PARITY_EN
    logic [BE_WIDTH-1:0] s1_par;
    logic [BE_WIDTH-1:0] s1_err;

    always_comb begin
        s1_par = '0;
        for (int unsigned l = 0; l < BE_WIDTH; l++) begin
            s1_par[l] = s1_word[l*LANE_W + BYTE_SIZE];
        end
    end
    assign s1_err = BE_WIDTH'(lane_parity(MAX_WORD_W'(s1_data), BYTE_SIZE)) ^ s1_par;
`endif

    // ---------------------------------------------------------------- stage 2
    if (OUTPUT_REG != 0) begin : g_out_reg
        logic                  s2_valid;
        logic [DATA_WIDTH-1:0] s2_data;
`ifdef SDPRAM_PARITY_EN
        logic [BE_WIDTH-1:0]   s2_err;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
`ifdef SDPRAM_PARITY_EN
                s2_err   <= '0;
`endif
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
`ifdef SDPRAM_PARITY_EN
                    s2_err  <= s1_err;
`endif
                end
            end
        end

        assign rd_valid = s2_valid;
        assign rd_data  = s2_data;
`ifdef SDPRAM_PARITY_EN
        assign rd_par_err = s2_err;
`endif
    end else begin : g_no_out_reg
        assign rd_valid = s1_valid;
        assign rd_data  = s1_data;
`ifdef SDPRAM_PARITY_EN
        assign rd_par_err = s1_err;
`endif
    end

endmodule

// File: tb/tb_sdpram_be_bypass.sv
// Bench for sdpram_be_bypass. It drives identical stimulus into a latency-2
// instance (OUTPUT_REG=1) and a latency-1 instance (OUTPUT_REG=0). Both are
// compared every cycle against a word-array model with per-byte masks.
module tb_sdpram_be_bypass;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byte_en;
    logic [3:0]  wr_par_inj;
    logic        rd_en;
    logic [11:0] rd_addr;

    logic [31:0] rd_data_2, rd_data_1;
    logic        rd_valid_2, rd_valid_1;
`ifdef SDPRAM_PARITY_EN
    logic [3:0]  rd_par_err_2, rd_par_err_1;
`endif

    always #5 clk = ~clk;

    sdpram_be_bypass #(.OUTPUT_REG(1)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_byte_en (wr_byte_en),
`ifdef SDPRAM_PARITY_EN
        .wr_par_inj (wr_par_inj),
        .rd_par_err (rd_par_err_2),
`endif
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data_2),
        .rd_valid   (rd_valid_2)
    );

    sdpram_be_bypass #(.OUTPUT_REG(0)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_byte_en (wr_byte_en),
`ifdef SDPRAM_PARITY_EN
        .wr_par_inj (wr_par_inj),
        .rd_par_err (rd_par_err_1),
`endif
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data_1),
        .rd_valid   (rd_valid_1)
    );

    // Reference model: memory words, injected-parity lanes, and the expected
    // output of each latency.
    logic [31:0] mem_m  [32];
    logic [3:0]  flip_m [32];
    logic [31:0] l1_d, l2_d;
    logic [3:0]  l1_e, l2_e;
    logic        l1_v, l2_v;

    int    n_cmp  = 0;
    int    n_fail = 0;
    string phase  = "reset";

    function automatic logic [31:0] bytemask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s [%s] got %h exp %h", tag, phase, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("lat2_valid", {31'b0, rd_valid_2}, {31'b0, l2_v});
        chk("lat2_data", rd_data_2, l2_d);
        chk("lat1_valid", {31'b0, rd_valid_1}, {31'b0, l1_v});
        chk("lat1_data", rd_data_1, l1_d);
`ifdef SDPRAM_PARITY_EN
        if (l2_v) chk("lat2_par_err", {28'b0, rd_par_err_2}, {28'b0, l2_e});
        if (l1_v) chk("lat1_par_err", {28'b0, rd_par_err_1}, {28'b0, l1_e});
`endif
    endtask

    // One clock: apply inputs, predict, clock, then check #1 after the edge.
    task automatic cyc(input logic we, input int wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input int ra,
                       input logic [3:0] inj);
        logic [31:0] bm, cap_d;
        logic [3:0]  cap_e;
        wr_en      = we;
        wr_addr    = 12'(wa);
        wr_data    = wd;
        wr_byte_en = be;
        wr_par_inj = inj;
        rd_en      = re;
        rd_addr    = 12'(ra);
        bm    = (we && wa == ra) ? bytemask(be) : 32'h0;
        cap_d = (mem_m[ra] & ~bm) | (wd & bm);
        cap_e = (we && wa == ra) ? ((flip_m[ra] & ~be) | (inj & be)) : flip_m[ra];
        if (we) begin
            mem_m[wa]  = (mem_m[wa] & ~bytemask(be)) | (wd & bytemask(be));
            flip_m[wa] = (flip_m[wa] & ~be) | (inj & be);
        end
        @(posedge clk);
        #1;
        l2_v = l1_v;
        if (l1_v) begin
            l2_d = l1_d;
            l2_e = l1_e;
        end
        l1_v = re;
        if (re) begin
            l1_d = cap_d;
            l1_e = cap_e;
        end
        check_outputs();
    endtask

    task automatic idle();
        cyc(1'b0, 0, 32'h0, 4'h0, 1'b0, 0, 4'h0);
    endtask

    task automatic clear_model_pipe();
        l1_v = 1'b0; l2_v = 1'b0;
        l1_d = '0;   l2_d = '0;
        l1_e = '0;   l2_e = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_byte_en = '0; wr_par_inj = '0;
        rd_en = 1'b0; rd_addr = '0;
        clear_model_pipe();
        for (int i = 0; i < 32; i++) begin
            mem_m[i]  = '0;
            flip_m[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Give every model address defined contents.
        phase = "init";
        for (int a = 0; a < 32; a++) cyc(1'b1, a, $urandom, 4'hF, 1'b0, 0, 4'h0);

        phase = "full_write_read";
        cyc(1'b1, 5, 32'hDEADBEEF, 4'hF, 1'b0, 0, 4'h0);
        cyc(1'b0, 0, 32'h0, 4'h0, 1'b1, 5, 4'h0);
        chk("t1_lat1_data", rd_data_1, 32'hDEADBEEF);
        idle();
        chk("t1_lat2_valid", {31'b0, rd_valid_2}, 32'h1);
        chk("t1_lat2_data", rd_data_2, 32'hDEADBEEF);
        idle();

        phase = "partial_write";
        cyc(1'b1, 7, 32'h11223344, 4'hF, 1'b0, 0, 4'h0);
        cyc(1'b1, 7, 32'hAABBCCDD, 4'b0101, 1'b0, 0, 4'h0);
        cyc(1'b1, 7, 32'h55555555, 4'h0, 1'b1, 7, 4'h0);
        idle();
        chk("t2_lat2_data", rd_data_2, 32'h11BB33DD);

        phase = "collision";
        cyc(1'b1, 9, 32'h0, 4'hF, 1'b0, 0, 4'h0);
        cyc(1'b1, 9, 32'hFFFF0000, 4'b1100, 1'b1, 9, 4'h0);
        cyc(1'b0, 0, 32'h0, 4'h0, 1'b1, 9, 4'h0);
        idle();
        chk("t3_lat2_second", rd_data_2, 32'hFFFF0000);
        idle();

        phase = "stream";
        for (int a = 0; a < 16; a++) cyc(1'b0, 0, 32'h0, 4'h0, 1'b1, a, 4'h0);
        idle(); idle();

        phase = "midflight_reset";
        cyc(1'b0, 0, 32'h0, 4'h0, 1'b1, 5, 4'h0);
        rst_n = 1'b0;
        #1;
        clear_model_pipe();
        check_outputs();
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        repeat (3) idle();
        cyc(1'b0, 0, 32'h0, 4'h0, 1'b1, 5, 4'h0);
        idle(); idle();

`ifdef SDPRAM_PARITY_EN
        phase = "parity";
        cyc(1'b1, 3, 32'hCAFEF00D, 4'hF, 1'b0, 0, 4'b0010);
        cyc(1'b0, 0, 32'h0, 4'h0, 1'b1, 3, 4'h0);
        idle();
        chk("t6_inj", {28'b0, rd_par_err_2}, 32'h2);
        cyc(1'b1, 3, 32'h0BADF00D, 4'hF, 1'b0, 0, 4'h0);
        cyc(1'b0, 0, 32'h0, 4'h0, 1'b1, 3, 4'h0);
        idle();
        chk("t6_clean", {28'b0, rd_par_err_2}, 32'h0);
`endif

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            int wa, ra;
            wa = int'($urandom_range(0, 15));
            ra = ($urandom_range(0, 1) == 1) ? wa : int'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), ra,
`ifdef SDPRAM_PARITY_EN
                4'($urandom_range(0, 15))
`else
                4'h0
`endif
            );
        end
        idle(); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
